// File: rtl/axi2apb_txn_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi2apb_txn_scheduler_if : burst request / APB beat handshake bundle   |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
interface axi2apb_txn_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_len;
  logic [1:0]            wr_burst;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [3:0]            rd_len;
  logic [1:0]            rd_burst;
  logic                  rd_ack;
  logic                  fifo_empty;
  logic                  beat_start;
  logic                  beat_write;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  beat_last;
  logic                  beat_done;
  logic                  beat_err;
  logic                  wr_cmpl;
  logic                  rd_cmpl;
  logic                  wr_err;
  logic                  rd_err;
  logic                  busy;

  // master = scheduler side, slave = AXI front end plus APB engine
  modport master (
    input  wr_req, wr_addr, wr_len, wr_burst,
    input  rd_req, rd_addr, rd_len, rd_burst,
    input  fifo_empty, beat_done, beat_err,
    output wr_ack, rd_ack, beat_start, beat_write, beat_addr, beat_last,
    output wr_cmpl, rd_cmpl, wr_err, rd_err, busy
  );

  modport slave (
    output wr_req, wr_addr, wr_len, wr_burst,
    output rd_req, rd_addr, rd_len, rd_burst,
    output fifo_empty, beat_done, beat_err,
    input  wr_ack, rd_ack, beat_start, beat_write, beat_addr, beat_last,
    input  wr_cmpl, rd_cmpl, wr_err, rd_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/axi2apb_txn_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi2apb_txn_scheduler : arbitrates AXI wr/rd bursts onto one APB engine |
// | Option macro: AXI2APB_SCHED_WR_PRIORITY_EN (fixed write priority)       |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module axi2apb_txn_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  axi2apb_txn_scheduler_if.master     bus
);

  localparam int                    c_beat_bytes = DATA_WIDTH / 8;
  localparam int                    c_lsb        = $clog2(c_beat_bytes);
  localparam logic [ADDR_WIDTH-1:0] c_beat_step  = ADDR_WIDTH'(c_beat_bytes);
  localparam logic [ADDR_WIDTH-1:0] c_one        = ADDR_WIDTH'(1);
  localparam logic [1:0]            c_fixed      = 2'b00;
  localparam logic [1:0]            c_incr       = 2'b01;
  localparam logic [1:0]            c_wrap       = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CMPL  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_len;
  logic [3:0]            r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_wr_ack;
  logic                  r_rd_ack;
  logic                  r_beat_start;
  logic                  r_beat_last;
  logic                  r_wr_cmpl;
  logic                  r_rd_cmpl;
  logic                  r_wr_err;
  logic                  r_rd_err;
  logic                  r_busy;
`ifndef AXI2APB_SCHED_WR_PRIORITY_EN
  logic                  r_last_grant_wr;
`endif

  logic                  w_grant_any;
  logic                  w_grant_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [3:0]            w_sel_len;
  logic [1:0]            w_sel_burst;
  logic                  w_sel_bad;
  logic                  w_beat_ready;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_grant_any = bus.wr_req | bus.rd_req;
`ifdef AXI2APB_SCHED_WR_PRIORITY_EN
  assign w_grant_wr  = bus.wr_req;
`else
  assign w_grant_wr  = bus.wr_req & (~bus.rd_req | ~r_last_grant_wr);
`endif

  assign w_sel_addr  = w_grant_wr ? bus.wr_addr  : bus.rd_addr;
  assign w_sel_len   = w_grant_wr ? bus.wr_len   : bus.rd_len;
  assign w_sel_burst = w_grant_wr ? bus.wr_burst : bus.rd_burst;

  // Reserved type and illegal WRAP lengths fall back to INCR with an error.
  assign w_sel_bad = (w_sel_burst == 2'b11) ||
                     ((w_sel_burst == c_wrap) &&
                      !((w_sel_len == 4'd1) || (w_sel_len == 4'd3) ||
                        (w_sel_len == 4'd7) || (w_sel_len == 4'd15)));

  assign w_beat_ready = ~r_write | ~bus.fifo_empty;
  assign w_addr_inc   = r_addr + c_beat_step;
  assign w_wrap_mask  = (ADDR_WIDTH'({1'b0, r_len} + 5'd1) << c_lsb) - c_one;

  always_comb begin
    w_next_addr = w_addr_inc;
    case (r_burst)
      c_fixed: w_next_addr = r_addr;
      c_wrap:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default: w_next_addr = w_addr_inc;
    endcase
  end

  // CMPL arbitrates like IDLE so a back-to-back ack lands one cycle after cmpl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_write         <= 1'b0;
      r_addr          <= '0;
      r_len           <= '0;
      r_cnt           <= '0;
      r_burst         <= c_fixed;
      r_err           <= 1'b0;
      r_wr_ack        <= 1'b0;
      r_rd_ack        <= 1'b0;
      r_beat_start    <= 1'b0;
      r_beat_last     <= 1'b0;
      r_wr_cmpl       <= 1'b0;
      r_rd_cmpl       <= 1'b0;
      r_wr_err        <= 1'b0;
      r_rd_err        <= 1'b0;
      r_busy          <= 1'b0;
`ifndef AXI2APB_SCHED_WR_PRIORITY_EN
      r_last_grant_wr <= 1'b0;
`endif
    end else begin
      r_wr_ack     <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_beat_start <= 1'b0;
      r_wr_cmpl    <= 1'b0;
      r_rd_cmpl    <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_err     <= 1'b0;
      unique case (r_state)
        IDLE, CMPL: begin
          if (w_grant_any) begin
            r_wr_ack        <= w_grant_wr;
            r_rd_ack        <= ~w_grant_wr;
            r_write         <= w_grant_wr;
            r_addr          <= w_sel_addr;
            r_len           <= w_sel_len;
            r_burst         <= w_sel_bad ? c_incr : w_sel_burst;
            r_cnt           <= '0;
            r_err           <= w_sel_bad;
            r_beat_last     <= (w_sel_len == 4'd0);
            r_busy          <= 1'b1;
`ifndef AXI2APB_SCHED_WR_PRIORITY_EN
            r_last_grant_wr <= w_grant_wr;
`endif
            r_state         <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          if (w_beat_ready) begin
            r_beat_start <= 1'b1;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.beat_done) begin
            if (r_beat_last) begin
              r_wr_cmpl   <= r_write;
              r_rd_cmpl   <= ~r_write;
              r_wr_err    <= r_write & (r_err | bus.beat_err);
              r_rd_err    <= ~r_write & (r_err | bus.beat_err);
              r_err       <= 1'b0;
              r_beat_last <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= CMPL;
            end else begin
              r_err       <= r_err | bus.beat_err;
              r_addr      <= w_next_addr;
              r_cnt       <= r_cnt + 4'd1;
              r_beat_last <= ((r_cnt + 4'd1) == r_len);
              // Launch the next beat straight away when data is on hand.
              if (w_beat_ready) begin
                r_beat_start <= 1'b1;
              end else begin
                r_state <= ISSUE;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.wr_ack     = r_wr_ack;
  assign bus.rd_ack     = r_rd_ack;
  assign bus.beat_start = r_beat_start;
  assign bus.beat_write = r_write;
  assign bus.beat_addr  = r_addr;
  assign bus.beat_last  = r_beat_last;
  assign bus.wr_cmpl    = r_wr_cmpl;
  assign bus.rd_cmpl    = r_rd_cmpl;
  assign bus.wr_err     = r_wr_err;
  assign bus.rd_err     = r_rd_err;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_axi2apb_txn_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axi2apb_txn_scheduler : directed bench with an APB engine responder |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_axi2apb_txn_scheduler;

  logic clk;
  logic rst_n;

  axi2apb_txn_scheduler_if #(.ADDR_WIDTH(32)) bus ();

  axi2apb_txn_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;

  // Responder / monitor state (written only by the responder process)
  int          cyc = 0;
  int          log_n = 0;
  logic [31:0] log_addr [32];
  logic        log_last [32];
  int          log_cyc  [32];
  int          beat_idx = 0;
  bit          pend = 0;
  int          wait_n = 0;
  int          done_cyc = 0;
  int          cmpl_n = 0;
  int          cmpl_cyc = 0;
  logic        last_cmpl_wr = 0;
  logic        last_cmpl_err = 0;
  int          grant_n = 0;
  logic        grant_log [16];
  int          ack_cyc   [16];

  // Written only by the main process
  bit          eng_clear = 0;
  logic        err_plan [16];
  logic [31:0] exp_a [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] out_vec();
    return {22'd0, bus.wr_ack, bus.rd_ack, bus.beat_start, bus.beat_write,
            bus.beat_addr, bus.beat_last, bus.wr_cmpl, bus.rd_cmpl,
            bus.wr_err, bus.rd_err, bus.busy};
  endfunction

  // APB engine model: done two cycles after each start, error from err_plan.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    bus.beat_done = 1'b0;
    bus.beat_err  = 1'b0;
    if (eng_clear) begin
      log_n = 0; beat_idx = 0; pend = 0; cmpl_n = 0; grant_n = 0;
    end else begin
      if (pend) begin
        if (wait_n == 1) begin
          bus.beat_done = 1'b1;
          bus.beat_err  = err_plan[beat_idx % 16];
          beat_idx++;
          done_cyc = cyc;
          pend = 0;
        end else begin
          wait_n--;
        end
      end
      if (bus.beat_start && log_n < 32) begin
        log_addr[log_n] = bus.beat_addr;
        log_last[log_n] = bus.beat_last;
        log_cyc[log_n]  = cyc;
        log_n++;
        pend   = 1;
        wait_n = 2;
      end
      if ((bus.wr_ack || bus.rd_ack) && grant_n < 16) begin
        grant_log[grant_n] = bus.wr_ack;
        ack_cyc[grant_n]   = cyc;
        grant_n++;
      end
      if (bus.wr_cmpl || bus.rd_cmpl) begin
        cmpl_n++;
        cmpl_cyc      = cyc;
        last_cmpl_wr  = bus.wr_cmpl;
        last_cmpl_err = bus.wr_cmpl ? bus.wr_err : bus.rd_err;
      end
    end
  end

  task automatic clear_engine;
    for (int i = 0; i < 16; i++) err_plan[i] = 1'b0;
    eng_clear = 1'b1;
    tick;
    eng_clear = 1'b0;
  endtask

  task automatic wait_cmpl(input int target);
    for (int i = 0; i < 300 && cmpl_n < target; i++) tick;
  endtask

  task automatic run_burst(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst,
                           input logic exp_err);
    int  n;
    bit  got;
    n = int'(len) + 1;
    if (wr) begin
      bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_len = len; bus.wr_burst = burst;
    end else begin
      bus.rd_req = 1'b1; bus.rd_addr = addr; bus.rd_len = len; bus.rd_burst = burst;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (bus.wr_ack || bus.rd_ack) got = 1;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    check({tag, "_ack"}, {62'd0, bus.wr_ack, bus.rd_ack}, wr ? 64'd2 : 64'd1);
    check({tag, "_busy_dir"}, {62'd0, bus.busy, bus.beat_write}, {62'd0, 1'b1, wr});
    wait_cmpl(1);
    check({tag, "_cmpl"}, 64'(cmpl_n), 64'd1);
    check({tag, "_cmpl_dir"}, 64'(last_cmpl_wr), 64'(wr));
    check({tag, "_err"}, 64'(last_cmpl_err), 64'(exp_err));
    check({tag, "_beats"}, 64'(log_n), 64'(n));
    for (int i = 0; i < n && i < log_n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(exp_a[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(log_last[i]), 64'(i == n - 1));
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i), 64'(log_cyc[i] - log_cyc[i-1]), 64'd3);
    end
    if (log_n > 0 && grant_n > 0)
      check({tag, "_ack2start"}, 64'(log_cyc[0] - ack_cyc[0]), 64'd1);
    check({tag, "_done2cmpl"}, 64'(cmpl_cyc - done_cyc), 64'd1);
    repeat (4) tick;
    check({tag, "_one_cmpl"}, 64'(cmpl_n), 64'd1);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    clear_engine;
  endtask

  initial begin : main
    int  starts;
    int  cmpl_before;
    bit  got;
    rst_n = 1'b0;
    bus.wr_req = 0; bus.wr_addr = 0; bus.wr_len = 0; bus.wr_burst = 0;
    bus.rd_req = 0; bus.rd_addr = 0; bus.rd_len = 0; bus.rd_burst = 0;
    bus.fifo_empty = 1'b0;
    for (int i = 0; i < 16; i++) err_plan[i] = 1'b0;
    repeat (3) tick;
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    clear_engine;

    // Tie, 3 rounds; last_grant resets to read so write goes first.
    bus.wr_addr = 32'h500; bus.wr_len = 0; bus.wr_burst = 2'b01;
    bus.rd_addr = 32'h600; bus.rd_len = 0; bus.rd_burst = 2'b01;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int i = 0; i < 200 && grant_n < 6; i++) tick;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check("tie_grants", 64'(grant_n), 64'd6);
    for (int k = 0; k < 6 && k < grant_n; k++) begin
`ifdef AXI2APB_SCHED_WR_PRIORITY_EN
      check($sformatf("tie_grant%0d", k), 64'(grant_log[k]), 64'd1);
`else
      check($sformatf("tie_grant%0d", k), 64'(grant_log[k]), 64'((k % 2) == 0));
`endif
    end
    if (grant_n > 1) check("b2b_ack_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'd5);
    wait_cmpl(6);
    check("tie_cmpls", 64'(cmpl_n), 64'd6);
    repeat (3) tick;
    clear_engine;

    exp_a[0] = 32'h1000; exp_a[1] = 32'h1004; exp_a[2] = 32'h1008; exp_a[3] = 32'h100C;
    run_burst("incr_rd", 1'b0, 32'h1000, 4'd3, 2'b01, 1'b0);

    exp_a[0] = 32'h2008; exp_a[1] = 32'h200C; exp_a[2] = 32'h2000; exp_a[3] = 32'h2004;
    run_burst("wrap_wr", 1'b1, 32'h2008, 4'd3, 2'b10, 1'b0);

    exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0000_0000;
    run_burst("incr_wrap32", 1'b0, 32'hFFFF_FFFC, 4'd1, 2'b01, 1'b0);

    exp_a[0] = 32'h40; exp_a[1] = 32'h40; exp_a[2] = 32'h40;
    run_burst("fixed_rd", 1'b0, 32'h40, 4'd2, 2'b00, 1'b0);

    exp_a[0] = 32'h10; exp_a[1] = 32'h14; exp_a[2] = 32'h18;
    run_burst("wrap_badlen", 1'b0, 32'h10, 4'd2, 2'b10, 1'b1);

    exp_a[0] = 32'h100; exp_a[1] = 32'h104;
    run_burst("rsvd_type", 1'b1, 32'h100, 4'd1, 2'b11, 1'b1);

    // Write with FIFO empty: no start until it drops; error on beat 0 is sticky.
    err_plan[0] = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 32'h800; bus.wr_len = 4'd1; bus.wr_burst = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (bus.wr_ack) got = 1;
    end
    bus.wr_req = 1'b0;
    check("stall_ack", 64'(bus.wr_ack), 64'd1);
    starts = 0;
    repeat (5) begin
      tick;
      starts += int'(bus.beat_start);
    end
    check("stall_no_start", 64'(starts), 64'd0);
    bus.fifo_empty = 1'b0;
    tick;
    check("stall_start", 64'(bus.beat_start), 64'd1);
    wait_cmpl(1);
    check("stall_beats", 64'(log_n), 64'd2);
    check("stall_cmpl_dir", 64'(last_cmpl_wr), 64'd1);
    check("stall_err", 64'(last_cmpl_err), 64'd1);
    repeat (3) tick;
    clear_engine;

    // 16-beat write, reset during WAIT of beat 3.
    bus.wr_req = 1'b1; bus.wr_addr = 32'h3000; bus.wr_len = 4'd15; bus.wr_burst = 2'b01;
    for (int i = 0; i < 20 && grant_n < 1; i++) tick;
    bus.wr_req = 1'b0;
    for (int i = 0; i < 100 && log_n < 3; i++) tick;
    check("mid_beats", 64'(log_n), 64'd3);
    tick;
    check("mid_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 64'd0);
    repeat (2) tick;
    rst_n = 1'b1;
    cmpl_before = cmpl_n;
    repeat (10) tick;
    check("reset_no_cmpl", 64'(cmpl_n), 64'(cmpl_before));
    clear_engine;
    bus.wr_addr = 32'h700; bus.wr_len = 0; bus.wr_burst = 2'b01;
    bus.rd_addr = 32'h780; bus.rd_len = 0; bus.rd_burst = 2'b01;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int i = 0; i < 20 && grant_n < 1; i++) tick;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check("post_reset_tie", {62'd0, bus.wr_ack, bus.rd_ack}, 64'd2);
    wait_cmpl(1);
    check("post_reset_cmpl", 64'(cmpl_n), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
